holy_axi_arbiter: RTL



---
 rtl/holy_axi_arb_pkg.sv | 24 ++
 rtl/axi_if.sv | 58 +++++
 rtl/holy_rr_pick2.sv | 24 ++
 rtl/holy_axi_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/holy_axi_arb_pkg.sv
// Shared types and defaults for the I/D-cache AXI arbiter.
package holy_axi_arb_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [AXI_ID_W-1:0] DEF_I_ID    = 4'd0;
  localparam logic [AXI_ID_W-1:0] DEF_D_ID    = 4'd1;
  localparam int                  DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_I_RD = 2'd1,
    ST_D_RD = 2'd2,
    ST_D_WR = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle shared by the caches and the core's external master port.
interface axi_if;
  import holy_axi_arb_pkg::*;

  logic                    aclk;
  logic                    aresetn;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport mst (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slv (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/holy_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// whichever side was not granted last.
module holy_rr_pick2
  import holy_axi_arb_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  src_t last_grant_i,
  output logic gnt_valid_o,
  output src_t gnt_src_o
);

  // Pick the winner among the current requests.
  always_comb begin
    gnt_valid_o = req_i_i | req_d_i;
    gnt_src_o   = SRC_D;
    if (req_i_i && req_d_i) begin
      gnt_src_o = (last_grant_i == SRC_D) ? SRC_I : SRC_D;
    end else if (req_i_i) begin
      gnt_src_o = SRC_I;
    end
  end

endmodule

// File: rtl/holy_axi_arbiter.sv
// Shares the core's AXI4 master port between the I-cache and D-cache, one
// whole transaction (address, data, response) at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | nothing granted, all forwarded valid/ready low
//   I_RD    | I-cache AR + R channels passed through
//   D_RD    | D-cache AR + R channels passed through
//   D_WR    | D-cache AW + W + B channels passed through
module holy_axi_arbiter
  import holy_axi_arb_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] I_ID    = DEF_I_ID,
  parameter logic [AXI_ID_W-1:0] D_ID    = DEF_D_ID,
  parameter int                  TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  axi_if.slv         s_axi_i,
  axi_if.slv         s_axi_d,
  axi_if.mst         m_axi,
  output logic [1:0] grant_state,
  output logic       timeout_err
);

  localparam int               CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_t       state_q, state_d;
  src_t             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pick_valid;
  src_t             pick_src;

  // A D-cache writeback (AW) is offered alongside its refill (AR); either counts as a request.
  holy_rr_pick2 u_pick (
    .req_i_i      (s_axi_i.arvalid),
    .req_d_i      (s_axi_d.awvalid | s_axi_d.arvalid),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (pick_valid),
    .gnt_src_o    (pick_src)
  );

  // State, round-robin memory and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_D;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE after the last R beat or the B handshake.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_src;
          if (pick_src == SRC_I)      state_d = ST_I_RD;
          else if (s_axi_d.awvalid)   state_d = ST_D_WR;
          else                        state_d = ST_D_RD;
        end
      end
      ST_I_RD, ST_D_RD: begin
        if (m_axi.rvalid && m_axi.rready && m_axi.rlast) state_d = ST_IDLE;
      end
      ST_D_WR: begin
        if (m_axi.bvalid && m_axi.bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog: counts open-grant cycles, saturating; the error flag is sticky until reset.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE)   cnt_d = '0;
    else if (cnt_q != '1)     cnt_d = cnt_q + CNT_W'(1);
    err_d = err_q | ((state_q != ST_IDLE) && (cnt_d >= TO_CNT));
  end

  // Channel muxes: only the granted channel set sees valid/ready; everything else is held low.
  always_comb begin
    m_axi.awid    = '0;
    m_axi.awaddr  = '0;
    m_axi.awlen   = '0;
    m_axi.awsize  = '0;
    m_axi.awburst = '0;
    m_axi.awvalid = 1'b0;
    m_axi.wdata   = '0;
    m_axi.wstrb   = '0;
    m_axi.wlast   = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    m_axi.arid    = '0;
    m_axi.araddr  = '0;
    m_axi.arlen   = '0;
    m_axi.arsize  = '0;
    m_axi.arburst = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    s_axi_i.arready = 1'b0;
    s_axi_i.rvalid  = 1'b0;
    s_axi_d.arready = 1'b0;
    s_axi_d.rvalid  = 1'b0;
    s_axi_d.awready = 1'b0;
    s_axi_d.wready  = 1'b0;
    s_axi_d.bvalid  = 1'b0;
    unique case (state_q)
      ST_I_RD: begin
        m_axi.arid      = I_ID;
        m_axi.araddr    = s_axi_i.araddr;
        m_axi.arlen     = s_axi_i.arlen;
        m_axi.arsize    = s_axi_i.arsize;
        m_axi.arburst   = s_axi_i.arburst;
        m_axi.arvalid   = s_axi_i.arvalid;
        s_axi_i.arready = m_axi.arready;
        s_axi_i.rvalid  = m_axi.rvalid;
        m_axi.rready    = s_axi_i.rready;
      end
      ST_D_RD: begin
        m_axi.arid      = D_ID;
        m_axi.araddr    = s_axi_d.araddr;
        m_axi.arlen     = s_axi_d.arlen;
        m_axi.arsize    = s_axi_d.arsize;
        m_axi.arburst   = s_axi_d.arburst;
        m_axi.arvalid   = s_axi_d.arvalid;
        s_axi_d.arready = m_axi.arready;
        s_axi_d.rvalid  = m_axi.rvalid;
        m_axi.rready    = s_axi_d.rready;
      end
      ST_D_WR: begin
        m_axi.awid      = D_ID;
        m_axi.awaddr    = s_axi_d.awaddr;
        m_axi.awlen     = s_axi_d.awlen;
        m_axi.awsize    = s_axi_d.awsize;
        m_axi.awburst   = s_axi_d.awburst;
        m_axi.awvalid   = s_axi_d.awvalid;
        s_axi_d.awready = m_axi.awready;
        m_axi.wdata     = s_axi_d.wdata;
        m_axi.wstrb     = s_axi_d.wstrb;
        m_axi.wlast     = s_axi_d.wlast;
        m_axi.wvalid    = s_axi_d.wvalid;
        s_axi_d.wready  = m_axi.wready;
        s_axi_d.bvalid  = m_axi.bvalid;
        m_axi.bready    = s_axi_d.bready;
      end
      default: ;
    endcase
  end

  // Response payloads are safe to fan out to both caches; only the valids are gated.
  assign s_axi_i.rid     = m_axi.rid;
  assign s_axi_i.rdata   = m_axi.rdata;
  assign s_axi_i.rresp   = m_axi.rresp;
  assign s_axi_i.rlast   = m_axi.rlast;
  assign s_axi_d.rid     = m_axi.rid;
  assign s_axi_d.rdata   = m_axi.rdata;
  assign s_axi_d.rresp   = m_axi.rresp;
  assign s_axi_d.rlast   = m_axi.rlast;
  assign s_axi_d.bid     = m_axi.bid;
  assign s_axi_d.bresp   = m_axi.bresp;

  // The I-cache never writes.
  assign s_axi_i.awready = 1'b0;
  assign s_axi_i.wready  = 1'b0;
  assign s_axi_i.bvalid  = 1'b0;
  assign s_axi_i.bid     = '0;
  assign s_axi_i.bresp   = '0;

  assign grant_state = state_q;
  assign timeout_err = err_q;

endmodule
